tree_path_decoder: RTL and testbench
====================================

# tree_path_decoder

Streaming decoder for hierarchical instance paths in the generated module trees (root → `sa0` … `sa9` levels, up to five children per node). It accepts a path as a sequence of per-level child-index digits over a valid/ready handshake and emits one flat mixed-radix leaf ID per path. A path-encoding block turns a leaf ID into per-level digits; this block does the reverse. It sits between the test-harness command stream and the leaf-select logic of a generated tree.

## Interface
- `DEPTH`, 10, maximum digits (levels) per path.
- `FANOUT`, 5, radix; legal digit range 0..FANOUT-1.
- `ID_W`, 24, output ID width; must satisfy FANOUT^DEPTH ≤ 2^ID_W.
- `clk` in 1, sole clock.
- `rst` in 1, synchronous, active-high reset.
- `in_valid` in 1, digit present.
- `in_ready` out 1, decoder accepts the digit this cycle.
- `in_digit` in 4, child index at the current level.
- `in_last` in 1, final digit of the path.
- `out_valid` out 1, decoded path available.
- `out_ready` in 1, consumer accepts the result.
- `out_id` out ID_W, leaf ID, most-significant digit first.
- `out_depth` out 4, number of digits in the path, 1..DEPTH.
- `out_err` out 1, path was malformed.

## Operation
- FSM states: IDLE, ACCUM, DRAIN, OUT.
- A digit is accepted when `in_valid && in_ready`. `in_ready` = 1 in IDLE, ACCUM, and DRAIN, and 0 in OUT.
- IDLE accept: acc = digit, cnt = 1.
- ACCUM accept: acc = acc*FANOUT + digit, cnt = cnt+1. The arithmetic is done at ID_W bits; the product is truncated to ID_W.
- Accepting with `in_last` = 1 from IDLE or ACCUM goes to OUT.
- Digit error: `in_digit` ≥ FANOUT sets err. acc is not updated by that digit.
- Overflow error: a digit accepted when cnt == DEPTH sets err. cnt saturates at DEPTH.
- Any error without `in_last` goes to DRAIN. DRAIN discards digits until `in_last`, then goes to OUT.
- OUT: `out_valid` = 1. `out_id` = acc, or 0 if err. `out_depth` = cnt. `out_err` = err.
- OUT holds its values stable until `out_ready`. After the output handshake the FSM returns to IDLE and clears err.
- A path of a single digit with `in_last` set is legal; `out_depth` = 1.

## Timing
- Reset values: `in_ready` = 0 during reset, then 1 in the first cycle after reset. `out_valid` = 0, `out_id` = 0, `out_depth` = 0, `out_err` = 0. FSM = IDLE.
- Latency: `out_valid` rises in the cycle after the `in_last` digit is accepted.
- Throughput: an N-digit path takes N+1 cycles minimum (one bubble in OUT).
- When `out_ready` is asserted in the cycle `out_valid` rises, `in_ready` = 1 in the next cycle.
- `in_valid` while in OUT is not accepted; the producer holds the digit.
- Reset asserted mid-path or in OUT discards the partial or pending result at the next clock edge. No output handshake completes.

## Configuration
- Macro: `TREE_PATH_DEC_STATS_EN`.
- Defined: adds output ports `stat_paths` [15:0] and `stat_errs` [15:0].
  - `stat_paths` increments on every output handshake.
  - `stat_errs` increments on every output handshake that has `out_err` = 1.
  - Both wrap at 2^16 and reset to 0.
- Undefined: the ports and counters are absent. Core behaviour is identical.

## Structure
- Package `tree_path_pkg` holds:
  - the `tree_path_state_t` enum (IDLE, ACCUM, DRAIN, OUT);
  - the `DIGIT_W` = 4 constant;
  - the `TREE_DEPTH` and `TREE_FANOUT` default constants.
- Sub-module `tree_path_mac` is natural. It is combinational: acc*FANOUT + digit at ID_W bits, plus a digit-range check output.
- FSM, counters, and output registers live in `tree_path_decoder`.

## Test plan
- Digits 2,4,1 (last on 1), `out_ready` = 1 → `out_id` = 2·25+4·5+1 = 71, `out_depth` = 3, `out_err` = 0. `out_valid` is seen one cycle after the last digit.
- Ten digits of 4, last on the tenth → `out_id` = 9765624 (5^10−1), `out_depth` = 10, `out_err` = 0.
- Eleven digits, last on the eleventh → `out_err` = 1, `out_id` = 0, `out_depth` = 10.
- Digits 1,7,3 (last on 3) → `out_err` = 1, `out_id` = 0. The digit 3 is consumed in DRAIN, and a following path decodes cleanly.
- Hold `out_ready` = 0 for 5 cycles with `in_valid` = 1 → `in_ready` = 0 and the outputs stay stable throughout. After release, the next path starts one cycle later.
- `rst` pulse after 2 of 3 digits, then digits 0,3 (last on 3) → `out_id` = 3, `out_depth` = 2. With `TREE_PATH_DEC_STATS_EN`, `stat_paths` = 1 and `stat_errs` = 0.

Source files
------------

// File: rtl/tree_path_pkg.sv
// tree_path_pkg: shared types and defaults for the tree path decoder.
// Holds the FSM state enum, digit width and default tree geometry.
package tree_path_pkg;

    localparam int DIGIT_W     = 4;
    localparam int TREE_DEPTH  = 10;
    localparam int TREE_FANOUT = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } tree_path_state_t;

endpackage

// File: rtl/tree_path_mac.sv
// tree_path_mac: combinational mixed-radix step, acc*FANOUT + digit.
// Ports: acc, digit in; next_acc (ID_W, truncated), digit_ok out.
module tree_path_mac
    import tree_path_pkg::*;
#(
    parameter int FANOUT = TREE_FANOUT,
    parameter int ID_W   = 24
) (
    input  logic [ID_W-1:0]    acc,
    input  logic [DIGIT_W-1:0] digit,
    output logic [ID_W-1:0]    next_acc,
    output logic               digit_ok
);

    localparam logic [ID_W-1:0]  RADIX = ID_W'(FANOUT);
    localparam logic [DIGIT_W:0] LIMIT = (DIGIT_W + 1)'(FANOUT);

    logic [ID_W-1:0] digit_ext;

    assign digit_ext = {{(ID_W - DIGIT_W){1'b0}}, digit};
    assign next_acc  = (acc * RADIX) + digit_ext;
    assign digit_ok  = {1'b0, digit} < LIMIT;

endmodule

// File: rtl/tree_path_decoder.sv
// tree_path_decoder: streams per-level child digits into a flat leaf ID.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_digit/in_last;
// out_valid/out_ready/out_id/out_depth/out_err.
// Optional TREE_PATH_DEC_STATS_EN adds stat_paths/stat_errs counters.
module tree_path_decoder
    import tree_path_pkg::*;
#(
    parameter int DEPTH  = TREE_DEPTH,
    parameter int FANOUT = TREE_FANOUT,
    parameter int ID_W   = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIGIT_W-1:0] in_digit,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ID_W-1:0]    out_id,
    output logic [3:0]         out_depth,
    output logic               out_err
`ifdef TREE_PATH_DEC_STATS_EN
    ,
    output logic [15:0]        stat_paths,
    output logic [15:0]        stat_errs
`endif
);

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    tree_path_state_t state;

    logic [ID_W-1:0] acc;
    logic [3:0]      cnt;
    logic            err;

    logic [ID_W-1:0] mac_acc;
    logic            digit_ok;

    logic [ID_W-1:0] nxt_acc;
    logic [3:0]      nxt_cnt;
    logic            nxt_err;
    logic            accept;
    logic            done;

    tree_path_mac #(
        .FANOUT (FANOUT),
        .ID_W   (ID_W)
    ) u_mac (
        .acc      (acc),
        .digit    (in_digit),
        .next_acc (mac_acc),
        .digit_ok (digit_ok)
    );

    assign in_ready = ~rst & (state != OUT);
    assign accept   = in_valid & in_ready;
    assign done     = out_valid & out_ready;

    // acc/cnt are zero in IDLE, so the first digit uses the same
    // datapath as later ones: 0*FANOUT + digit, cnt 0 -> 1.
    always_comb begin
        nxt_acc = acc;
        nxt_cnt = cnt;
        nxt_err = err;
        unique case (state)
            IDLE, ACCUM: begin
                if (cnt == DEPTH_C) begin
                    nxt_err = 1'b1;
                end else if (!digit_ok) begin
                    nxt_err = 1'b1;
                    nxt_cnt = cnt + 4'd1;
                end else begin
                    nxt_acc = mac_acc;
                    nxt_cnt = cnt + 4'd1;
                end
            end
            DRAIN: begin
                if (cnt != DEPTH_C) begin
                    nxt_cnt = cnt + 4'd1;
                end
            end
            default: begin
                nxt_acc = acc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_depth <= '0;
            out_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, ACCUM, DRAIN: begin
                    if (accept) begin
                        acc <= nxt_acc;
                        cnt <= nxt_cnt;
                        err <= nxt_err;
                        if (in_last) begin
                            state     <= OUT;
                            out_valid <= 1'b1;
                            out_id    <= nxt_err ? '0 : nxt_acc;
                            out_depth <= nxt_cnt;
                            out_err   <= nxt_err;
                        end else if (nxt_err) begin
                            state <= DRAIN;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                OUT: begin
                    if (done) begin
                        state     <= IDLE;
                        acc       <= '0;
                        cnt       <= '0;
                        err       <= 1'b0;
                        out_valid <= 1'b0;
                        out_id    <= '0;
                        out_depth <= '0;
                        out_err   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TREE_PATH_DEC_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_paths <= '0;
            stat_errs  <= '0;
        end else if (done) begin
            stat_paths <= stat_paths + 16'd1;
            if (out_err) begin
                stat_errs <= stat_errs + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tree_path_decoder.sv
// tb_tree_path_decoder: directed self-checking bench for tree_path_decoder.
// Hand-computed vectors, immediate assertions, one summary line.
module tb_tree_path_decoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_digit;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_id;
    logic [3:0]  out_depth;
    logic        out_err;
`ifdef TREE_PATH_DEC_STATS_EN
    logic [15:0] stat_paths;
    logic [15:0] stat_errs;
`endif

    int n_cmp;
    int n_bad;

    tree_path_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_depth (out_depth),
        .out_err   (out_err)
`ifdef TREE_PATH_DEC_STATS_EN
        ,
        .stat_paths (stat_paths),
        .stat_errs  (stat_errs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] d, input logic l);
        in_valid = 1'b1;
        in_digit = d;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_digit  = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_id", 32'(out_id), 0);
        chk("rst_out_depth", 32'(out_depth), 0);
        chk("rst_out_err", 32'(out_err), 0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // 2,4,1 -> 71
        out_ready = 1'b1;
        send(4'd2, 1'b0);
        chk("p1_no_valid_early", 32'(out_valid), 0);
        send(4'd4, 1'b0);
        send(4'd1, 1'b1);
        chk("p1_valid", 32'(out_valid), 1);
        chk("p1_id", 32'(out_id), 71);
        chk("p1_depth", 32'(out_depth), 3);
        chk("p1_err", 32'(out_err), 0);
        chk("p1_in_ready_out", 32'(in_ready), 0);
        step();
        chk("p1_valid_drop", 32'(out_valid), 0);
        chk("p1_in_ready_back", 32'(in_ready), 1);

        // ten 4s -> 5^10-1
        for (int i = 0; i < 10; i++) send(4'd4, i == 9);
        chk("p2_valid", 32'(out_valid), 1);
        chk("p2_id", 32'(out_id), 9765624);
        chk("p2_depth", 32'(out_depth), 10);
        chk("p2_err", 32'(out_err), 0);
        step();

        // eleven digits -> overflow
        for (int i = 0; i < 11; i++) send(4'd1, i == 10);
        chk("p3_valid", 32'(out_valid), 1);
        chk("p3_err", 32'(out_err), 1);
        chk("p3_id", 32'(out_id), 0);
        chk("p3_depth", 32'(out_depth), 10);
        step();

        // 1,7,3 -> digit error, 3 consumed in DRAIN
        send(4'd1, 1'b0);
        send(4'd7, 1'b0);
        chk("p4_drain_ready", 32'(in_ready), 1);
        chk("p4_drain_no_valid", 32'(out_valid), 0);
        send(4'd3, 1'b1);
        chk("p4_valid", 32'(out_valid), 1);
        chk("p4_err", 32'(out_err), 1);
        chk("p4_id", 32'(out_id), 0);
        chk("p4_depth", 32'(out_depth), 3);
        step();
        send(4'd3, 1'b1);
        chk("p5_valid", 32'(out_valid), 1);
        chk("p5_id", 32'(out_id), 3);
        chk("p5_depth", 32'(out_depth), 1);
        chk("p5_err", 32'(out_err), 0);
        step();

        // backpressure: 2,3 -> 13 held while out_ready=0
        out_ready = 1'b0;
        send(4'd2, 1'b0);
        send(4'd3, 1'b1);
        in_valid = 1'b1;
        in_digit = 4'd4;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_id", 32'(out_id), 13);
            chk("bp_depth", 32'(out_depth), 2);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(out_valid), 0);
        chk("bp_release_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_next_valid", 32'(out_valid), 1);
        chk("bp_next_id", 32'(out_id), 4);
        chk("bp_next_depth", 32'(out_depth), 1);
        step();

        // reset mid-path, then 0,3 -> 3
        send(4'd1, 1'b0);
        send(4'd2, 1'b0);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_ready", 32'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready_after", 32'(in_ready), 1);
        send(4'd0, 1'b0);
        send(4'd3, 1'b1);
        chk("p6_valid", 32'(out_valid), 1);
        chk("p6_id", 32'(out_id), 3);
        chk("p6_depth", 32'(out_depth), 2);
        chk("p6_err", 32'(out_err), 0);
        step();
        chk("p6_done", 32'(out_valid), 0);
`ifdef TREE_PATH_DEC_STATS_EN
        chk("stat_paths", 32'(stat_paths), 1);
        chk("stat_errs", 32'(stat_errs), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
